// File: rtl/seq_detect_pkg.sv
// Shared defaults for the parametrised sequence detector: widths, reset pattern
// and helpers that derive address/length widths from the maximum pattern length.
package seq_detect_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;

  // Power-up pattern is the legacy AA-AA-FF-CF frame marker, slot 0 first.
  localparam int RST_LEN = 4;
  localparam logic [7:0] RST_PAT [RST_LEN] = '{8'hAA, 8'hAA, 8'hFF, 8'hCF};

  function automatic int addr_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int rst_len(input int max_len);
    return (RST_LEN < max_len) ? RST_LEN : max_len;
  endfunction

  function automatic logic [7:0] rst_sym(input int slot);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < RST_LEN; k++) begin
      if (k == slot) s = RST_PAT[k];
    end
    return s;
  endfunction

endpackage

// File: rtl/seq_pattern_regs.sv
// Pattern register file and clamped length register for the sequence detector.
// Any configuration write raises flush so the detector restarts its history.
module seq_pattern_regs
  import seq_detect_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  localparam int ADDR_W = addr_w(MAX_LEN),
  localparam int LEN_W  = len_w(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic [DATA_W-1:0] pat [MAX_LEN],
  output logic [LEN_W-1:0]  len,
  output logic              flush
);

  assign flush = cfg_we | cfg_len_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        pat[i] <= DATA_W'(rst_sym(i));
      end
      len <= LEN_W'(rst_len(MAX_LEN));
    end else begin
      if (cfg_we && (int'(cfg_addr) < MAX_LEN)) begin
        pat[cfg_addr] <= cfg_data;
      end
      // Oversized lengths saturate rather than wrap.
      if (cfg_len_we) begin
        len <= (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Streaming detector for a programmable pattern of 1..MAX_LEN symbols, with
// overlap control and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int ADDR_W = addr_w(MAX_LEN),
  localparam int LEN_W  = len_w(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              data_valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              overlap,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              data_valid_out,
  output logic              detected_out,
  output logic [CNT_W-1:0]  match_count
);

  logic [DATA_W-1:0] pat [MAX_LEN];
  logic [DATA_W-1:0] hist [MAX_LEN];
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_m1;
  logic [LEN_W-1:0]  fill;
  logic              flush;
  logic              accept;
  logic              match;

  seq_pattern_regs #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_len_we (cfg_len_we),
    .cfg_len    (cfg_len),
    .pat        (pat),
    .len        (len),
    .flush      (flush)
  );

  assign accept = enable & data_valid_in & ~flush;
  assign len_m1 = len - LEN_W'(1);

  // The incoming beat is the last pattern symbol; hist[0] lines up with pat[len-2].
  always_comb begin
    match = 1'b0;
    if ((len != '0) && (fill >= len_m1)) begin
      match = (data_in == pat[len_m1[ADDR_W-1:0]]);
      for (int i = 0; i < MAX_LEN - 1; i++) begin
        if ((i < int'(len_m1)) && (hist[i] != pat[ADDR_W'(int'(len_m1) - 1 - i)])) begin
          match = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        hist[i] <= '0;
      end
      fill           <= '0;
      data_valid_out <= 1'b0;
      detected_out   <= 1'b0;
      match_count    <= '0;
    end else begin
      data_valid_out <= accept;
      detected_out   <= accept & match;
      if (accept && match && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + CNT_W'(1);
      end
      if (!enable || flush) begin
        fill <= '0;
      end else if (accept) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          hist[i] <= hist[i-1];
        end
        hist[0] <= data_in;
        // Non-overlap mode forgets everything once a match completes.
        if (match && !overlap) begin
          fill <= '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus a random
// stream compared against a queue-based reference model.
module tb_seq_detect_param;

  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       data_valid_in;
  logic [7:0] data_in;
  logic       overlap;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_len_we;
  logic [3:0] cfg_len;
  logic       dv, det, dv2, det2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  logic [7:0] pat_m [ML];
  int         len_m;
  logic [7:0] hq [$];
  int         cnt_m, cnt2_m;
  logic       exp_dv, exp_det;

  always #5 clk = ~clk;

  seq_detect_param #(.DATA_W(8), .MAX_LEN(ML), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_valid_in(data_valid_in),
    .data_in(data_in), .overlap(overlap), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
    .data_valid_out(dv), .detected_out(det), .match_count(cnt)
  );

  seq_detect_param #(.DATA_W(8), .MAX_LEN(ML), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .enable(enable), .data_valid_in(data_valid_in),
    .data_in(data_in), .overlap(overlap), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
    .data_valid_out(dv2), .detected_out(det2), .match_count(cnt2)
  );

  function automatic void model_reset();
    for (int i = 0; i < ML; i++) pat_m[i] = 8'h00;
    pat_m[0] = 8'hAA; pat_m[1] = 8'hAA; pat_m[2] = 8'hFF; pat_m[3] = 8'hCF;
    len_m = 4;
    hq.delete();
    cnt_m = 0;
    cnt2_m = 0;
  endfunction

  // Model: a match is the last len-1 remembered beats plus this beat equal to the pattern.
  task automatic step();
    logic acc, m;
    int n;
    acc = enable && data_valid_in && !cfg_we && !cfg_len_we;
    m = 1'b0;
    n = hq.size();
    if (acc && len_m != 0 && n >= len_m - 1) begin
      m = (data_in == pat_m[len_m-1]);
      for (int k = 0; k < len_m - 1; k++) begin
        if (hq[n - (len_m - 1) + k] != pat_m[k]) m = 1'b0;
      end
    end
    exp_dv = acc;
    exp_det = m;
    if (m) begin
      if (cnt_m < 65535) cnt_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
    if (cfg_we) pat_m[cfg_addr] = cfg_data;
    if (cfg_len_we) len_m = (int'(cfg_len) > ML) ? ML : int'(cfg_len);
    if (!enable || cfg_we || cfg_len_we) begin
      hq.delete();
    end else if (acc) begin
      if (m && !overlap) hq.delete();
      else begin
        hq.push_back(data_in);
        if (hq.size() > ML) void'(hq.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic v, input logic [7:0] d);
    enable = en; data_valid_in = v; data_in = d;
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    step();
  endtask

  task automatic wr_pat(input int a, input logic [7:0] d);
    enable = 1'b1; data_valid_in = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wr_len(input int l);
    enable = 1'b1; data_valid_in = 1'b0;
    cfg_len_we = 1'b1; cfg_len = 4'(l);
    step();
    cfg_len_we = 1'b0;
  endtask

  task automatic restore_default();
    wr_len(4);
    wr_pat(0, 8'hAA); wr_pat(1, 8'hAA); wr_pat(2, 8'hFF); wr_pat(3, 8'hCF);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; data_valid_in = 1'b0; data_in = 8'h00;
    overlap = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_len_we = 1'b0; cfg_len = '0;
    model_reset();
    #12;
    checks++;
    if (dv !== 1'b0 || det !== 1'b0 || cnt !== 16'd0 || cnt2 !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: dv=%b det=%b cnt=%0d cnt2=%0d expected all 0", dv, det, cnt, cnt2);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_default_pattern();
    logic [7:0] s [4] = '{8'hAA, 8'hAA, 8'hFF, 8'hCF};
    int ndet = 0;
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, s[i]);
      ndet += int'(det);
      checks++;
      if (dv !== 1'b1 || det !== (i == 3) || det !== exp_det || cnt !== 16'(cnt_m)) begin
        errors++;
        $display("[TB] FAIL default_beat%0d: dv=%b det=%b cnt=%0d expected dv=1 det=%b cnt=%0d", i, dv, det, cnt, exp_det, cnt_m);
      end
    end
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (ndet != 1 || cnt !== 16'd1 || dv !== 1'b0 || det !== 1'b0) begin
      errors++;
      $display("[TB] FAIL default_total: dets=%0d cnt=%0d dv=%b expected dets=1 cnt=1 dv=0", ndet, cnt, dv);
    end
  endtask

  task automatic test_overlap();
    int ndet;
    wr_len(2); wr_pat(0, 8'h55); wr_pat(1, 8'h55);
    for (int ov = 1; ov >= 0; ov--) begin
      drive(1'b0, 1'b0, 8'h00);
      overlap = logic'(ov);
      ndet = 0;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'b1, 8'h55);
        ndet += int'(det);
        checks++;
        if (det !== exp_det || dv !== 1'b1 || cnt !== 16'(cnt_m) || (ov == 0 && det !== (i % 2 == 1))) begin
          errors++;
          $display("[TB] FAIL overlap%0d_beat%0d: det=%b cnt=%0d expected det=%b cnt=%0d", ov, i, det, cnt, exp_det, cnt_m);
        end
      end
      checks++;
      if (ndet != ((ov == 1) ? 3 : 2)) begin
        errors++;
        $display("[TB] FAIL overlap%0d_total: dets=%0d expected %0d", ov, ndet, (ov == 1) ? 3 : 2);
      end
    end
    overlap = 1'b1;
    restore_default();
  endtask

  task automatic test_gaps_enable();
    logic [7:0] s [6] = '{8'hAA, 8'h00, 8'hAA, 8'hFF, 8'h00, 8'hCF};
    int ndet;
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b0, 1'b0, 8'h00);
      ndet = 0;
      for (int i = 0; i < 6; i++) begin
        drive((pass == 1 && i == 4) ? 1'b0 : 1'b1, (i == 1 || i == 4) ? 1'b0 : 1'b1, s[i]);
        ndet += int'(det);
        checks++;
        if (dv !== exp_dv || det !== exp_det || cnt !== 16'(cnt_m)) begin
          errors++;
          $display("[TB] FAIL gaps%0d_cycle%0d: dv=%b det=%b expected dv=%b det=%b", pass, i, dv, det, exp_dv, exp_det);
        end
      end
      checks++;
      if (ndet != ((pass == 0) ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL gaps%0d_total: dets=%0d expected %0d", pass, ndet, (pass == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_config();
    logic [7:0] s [4] = '{8'hAA, 8'hAA, 8'hFF, 8'hCF};
    wr_len(9);
    for (int i = 0; i < 8; i++) wr_pat(i, 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'(8'h10 + i));
      checks++;
      if (det !== (i == 7) || det !== exp_det) begin
        errors++;
        $display("[TB] FAIL clamp_len_beat%0d: det=%b expected %b", i, det, (i == 7));
      end
    end
    wr_len(0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, (i % 2 == 0) ? 8'h10 : 8'h11);
      checks++;
      if (dv !== 1'b1 || det !== 1'b0) begin
        errors++;
        $display("[TB] FAIL len0_beat%0d: dv=%b det=%b expected dv=1 det=0", i, dv, det);
      end
    end
    restore_default();
    drive(1'b1, 1'b1, 8'hAA); drive(1'b1, 1'b1, 8'hAA); drive(1'b1, 1'b1, 8'hFF);
    enable = 1'b1; data_valid_in = 1'b1; data_in = 8'hCF;
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 8'hCF; cfg_len_we = 1'b0;
    step();
    cfg_we = 1'b0;
    checks++;
    if (dv !== 1'b0 || det !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cfg_coincident_drop: dv=%b det=%b expected dv=0 det=0", dv, det);
    end
    drive(1'b1, 1'b1, 8'hCF);
    checks++;
    if (dv !== 1'b1 || det !== 1'b0 || det !== exp_det) begin
      errors++;
      $display("[TB] FAIL cfg_fill_cleared: dv=%b det=%b expected dv=1 det=0", dv, det);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 8'hAA); drive(1'b1, 1'b1, 8'hAA); drive(1'b1, 1'b1, 8'hFF);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (dv !== 1'b0 || det !== 1'b0 || cnt !== 16'd0 || dv2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: dv=%b det=%b cnt=%0d expected 0 0 0", dv, det, cnt);
    end
    model_reset();
    enable = 1'b0; data_valid_in = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 8'hCF);
    checks++;
    if (dv !== 1'b1 || det !== 1'b0 || det !== exp_det) begin
      errors++;
      $display("[TB] FAIL reset_history: dv=%b det=%b expected dv=1 det=0", dv, det);
    end
  endtask

  task automatic test_counter();
    logic [7:0] s [4] = '{8'hAA, 8'hAA, 8'hFF, 8'hCF};
    overlap = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, s[i]);
      checks++;
      if (det !== 1'b1 || det2 !== 1'b1 || cnt2 !== 2'(cnt2_m)) begin
        errors++;
        $display("[TB] FAIL counter_round%0d: det=%b det2=%b cnt2=%0d expected 1 1 %0d", r, det, det2, cnt2, cnt2_m);
      end
    end
    checks++;
    if (cnt2 !== 2'd3 || cnt !== 16'd5) begin
      errors++;
      $display("[TB] FAIL counter_saturate: cnt2=%0d cnt=%0d expected cnt2=3 cnt=5", cnt2, cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] alpha [3] = '{8'hAA, 8'hFF, 8'hCF};
    int r;
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      data_valid_in = ($urandom_range(0, 3) != 0);
      data_in = alpha[$urandom_range(0, 2)];
      overlap = logic'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      cfg_we = (r < 3);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_data = alpha[$urandom_range(0, 2)];
      cfg_len_we = (r >= 3 && r < 5);
      cfg_len = 4'($urandom_range(0, 15));
      step();
      cfg_we = 1'b0; cfg_len_we = 1'b0;
      checks++;
      if (dv !== exp_dv || det !== exp_det || cnt !== 16'(cnt_m) || cnt2 !== 2'(cnt2_m) || det2 !== exp_det) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: dv=%b det=%b cnt=%0d cnt2=%0d expected dv=%b det=%b cnt=%0d cnt2=%0d",
                 c, dv, det, cnt, cnt2, exp_dv, exp_det, cnt_m, cnt2_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_overlap();
    test_gaps_enable();
    test_config();
    test_reset_midstream();
    test_counter();
    restore_default();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised streaming sequence detector: watches a valid-qualified symbol stream and flags every occurrence of a runtime-programmable pattern of 1..MAX_LEN symbols. It generalises the fixed AA-AA-FF-CF detector in width, pattern length and content, and adds an overlap/non-overlap mode and a saturating match counter. It sits on the byte stream between the receive front end and the framing logic.

## Interface
- DATA_W, 8, symbol width in bits.
- MAX_LEN, 8, maximum pattern length in symbols (≥2).
- CNT_W, 16, match counter width.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset: asserting low clears state immediately; release is synchronous to clk.
- enable  in  1  high = detect; low = flush history, accept no beats.
- data_valid_in  in  1  beat qualifier for data_in.
- data_in  in  DATA_W  stream symbol.
- overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- cfg_we  in  1  pattern/length write strobe.
- cfg_addr  in  clog2(MAX_LEN)  pattern slot; slot 0 = first symbol of sequence.
- cfg_data  in  DATA_W  symbol written to slot cfg_addr.
- cfg_len_we  in  1  length write strobe.
- cfg_len  in  clog2(MAX_LEN+1)  new pattern length.
- data_valid_out  out  1  one-cycle strobe, one cycle after each accepted beat.
- detected_out  out  1  high with data_valid_out when that beat completed a match.
- match_count  out  CNT_W  saturating count of matches since reset.

## Operation
- Accepted beat: enable=1 and data_valid_in=1 and cfg_we=0 and cfg_len_we=0.
- History: shift register hist[0..MAX_LEN-1] (hist[0] newest) plus fill counter saturating at MAX_LEN.
- Match on an accepted beat: len≠0, fill ≥ len-1, data_in == pat[len-1] and hist[i] == pat[len-2-i] for i < len-1. Compare uses the incoming beat combinationally; result is registered.
- On accepted beat: shift data_in into hist[0], fill+1 (saturate). If match and overlap=0: fill cleared to 0 instead.
- enable=0: fill cleared every cycle; no outputs pulse; pattern retained.
- Any cfg_we or cfg_len_we: writes the register, clears fill, beat on that cycle is dropped (no data_valid_out).
- cfg_len of 0 disables detection (beats still echoed on data_valid_out); cfg_len > MAX_LEN is clamped to MAX_LEN.
- match_count increments by 1 per match, holds at all-ones.
- Reset values: pat = AA, AA, FF, CF (upper slots 0), len = 4, fill = 0, hist = 0, data_valid_out = 0, detected_out = 0, match_count = 0.

## Timing
- Latency: beat at edge N → data_valid_out/detected_out high for exactly the cycle after edge N; match_count updated at the same edge.
- No backpressure; one beat per cycle sustained; back-to-back matches each pulse (overlap=1, e.g. length-1 or periodic patterns).
- Gaps (data_valid_in=0) do not disturb history; outputs low in gap cycles.
- Reset mid-stream: outputs drop to 0 asynchronously; first possible detect is len accepted beats after release.
- Config write concurrent with data_valid_in: write wins, beat lost.
- detected_out is never high without data_valid_out.

## Structure
- Package seq_detect_pkg: DATA_W/MAX_LEN defaults, reset pattern constant array, reset length, derived address/length widths.
- One sub-module seq_pattern_regs: pattern register file plus length register with clamp, reset defaults and write-detected flush pulse.
- Top holds history, fill, comparator, output and counter registers.

## Test plan
- Default pattern, overlap=1: stream AA AA FF CF → single detected_out one cycle after CF beat; match_count=1.
- Overlap: program len=2, pat=55,55; stream 55 55 55 55 → overlap=1 gives 3 detects; overlap=0 gives 2 (after beats 2 and 4).
- Gaps and enable: AA, idle, AA, FF, idle, CF → detect; same stream with enable low for one cycle between FF and CF → no detect.
- Config: write cfg_len=9 with MAX_LEN=8 → length reads as 8; cfg_len=0 → no detects but data_valid_out echoes every beat; cfg_we coincident with beat → beat dropped, fill cleared.
- Reset: assert reset low after AA AA FF, release, send CF → no detect; outputs 0 during reset.
- Counter: CNT_W=2, five matches → match_count stops at 3.
